array_row_sequencer: RTL
========================

Name: array_row_sequencer

Overview:
- Parametrised successor to the left-side array row decoder of the Bayesian log2 memristor array.
- Decodes a full row address into sub-array select and column word-line (CWL) enables for any NARRAY.
- Generates the CWL pulse internally with a programmable-width counter; no external CWL strobe.
- Adds an autonomous row-scan mode and a start/busy/done handshake. Sits between the array controller and the left word-line drivers.

Parameters:
- NARRAY, 2, number of sub-array address bits.
- NWORD, 3, number of row-within-sub-array address bits.
- N, NWORD+NARRAY, full row address width.
- NSUB, 2**NARRAY, number of sub-arrays (one select and one CWL line each).
- PULSE_W, 4, width of the pulse-length input and counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  launch operation; sampled only in IDLE.
- abort  in  1  synchronous cancel of the current operation.
- mode  in  2  00 WRITE, 01 INFER, 10 READOUT, 11 SCAN; sampled with start.
- adr_full_row  in  N  [N-1:NWORD] sub-array, [NWORD-1:0] row; sampled with start.
- pulse_len  in  PULSE_W  CWL pulse length in cycles; sampled with start; 0 is treated as 1.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- sel  out  NSUB  registered sub-array select.
- cwl_en  out  NSUB  registered CWL enables.
- row_adr  out  NWORD  registered row address.
- reg_lrs  out  NWORD+2*NSUB  {sel, cwl_en, row_adr}; same cycle as the individual outputs.

Behaviour:
- All outputs are registered. Reset clears every output and sets state to IDLE.
- FSM states: IDLE, SETUP, PULSE, HOLD, CLEAR, FIN.
- Select rule:
  - WRITE: sel = one-hot of adr_full_row[N-1:NWORD].
  - INFER and SCAN: sel = all ones.
  - READOUT: sel = 0.
- Cycle timing, with start in IDLE at cycle 0 and L = max(pulse_len, 1):
  - WRITE / INFER:
    - Cycle 1 (SETUP): busy=1, sel and row_adr loaded, cwl_en=0.
    - Cycles 2..L+1 (PULSE): cwl_en = sel.
    - Cycle L+2 (HOLD): cwl_en=0, sel held.
    - Cycle L+3 (FIN): done=1, busy=0, return to IDLE.
  - SCAN: repeats SETUP/PULSE/HOLD for rows 0 .. 2**NWORD-1 in order.
    - Row counter increments in HOLD. Input row bits are ignored.
    - FIN follows the HOLD of the last row; no wrap-around.
    - Total length is 2**NWORD*(L+2)+1 cycles after start.
  - READOUT:
    - Cycle 1 (CLEAR): busy=1, sel, cwl_en and row_adr all 0.
    - Cycle 2 (FIN): done=1, busy=0.
- After FIN, sel and row_adr hold their last values until the next start or abort. cwl_en is always 0 outside PULSE.
- start while busy is ignored; no queuing. start together with done (FIN) is also ignored; a new start is accepted only from IDLE.
- abort in any non-IDLE state: next cycle IDLE, all outputs 0, no done. abort in IDLE clears sel and row_adr. rst has priority over abort, abort over start.
- The pulse counter loads L-1 on entry to PULSE and counts down to 0. pulse_len is not resampled mid-operation.
- Inputs changing during busy have no effect.

Decomposition:
- Shared package array_pkg:
  - mode enum (MODE_WRITE, MODE_INFER, MODE_READOUT, MODE_SCAN);
  - FSM state enum;
  - function onehot_sel(NARRAY-bit) returning NSUB bits.
- One sub-module, cwl_pulse_timer: loadable down-counter with a terminal flag, PULSE_W wide. FSM and output registers stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles with start=1 -> all outputs 0, busy=0, done never asserted.
- WRITE: adr_full_row=5'b10_011, pulse_len=3 ->
  - cycle 1: sel=4'b0100, row_adr=3, cwl_en=0;
  - cycles 2-4: cwl_en=4'b0100;
  - cycle 5: cwl_en=0;
  - cycle 6: done=1;
  - reg_lrs=11'b0100_0100_011 during pulse.
- INFER with pulse_len=0 -> exactly 1 cycle of cwl_en=4'b1111; done at cycle 4.
- SCAN with pulse_len=2 -> row_adr steps 0..7, eight 2-cycle pulses of 4'b1111; done at cycle 33; start pulses during busy ignored.
- READOUT after a WRITE -> cycle 1 all outputs 0, cycle 2 done=1.
- abort in the 2nd PULSE cycle of WRITE -> next cycle all outputs 0, busy=0, no done. Next start is accepted immediately.

Source files
------------

// File: rtl/array_pkg.sv
// Shared types and helpers for the array row sequencer.
// Mode and FSM encodings plus the sub-array one-hot decoder.
package array_pkg;

    localparam int MAX_ARRAY = 8;
    localparam int MAX_SUB   = 2 ** MAX_ARRAY;

    typedef enum logic [1:0] {
        MODE_WRITE   = 2'b00,
        MODE_INFER   = 2'b01,
        MODE_READOUT = 2'b10,
        MODE_SCAN    = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_CLEAR,
        S_FIN
    } state_e;

    // Sized for the widest supported array; callers keep the low NSUB bits.
    function automatic logic [MAX_SUB-1:0] onehot_sel(
        input logic [MAX_ARRAY-1:0] idx
    );
        logic [MAX_SUB-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/cwl_pulse_timer.sv
// Loadable down-counter timing the CWL pulse width.
// tc is high while the count sits at zero.
module cwl_pulse_timer #(
    parameter int PULSE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               dec,
    input  logic [PULSE_W-1:0] load_val,
    output logic [PULSE_W-1:0] count,
    output logic               tc
);

    assign tc = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !tc) begin
            count <= count - PULSE_W'(1);
        end
    end

endmodule

// File: rtl/array_row_sequencer.sv
// Row sequencer for the left word-line drivers of the memristor array.
// Decodes row addresses, times CWL pulses and scans all rows on request.
module array_row_sequencer
    import array_pkg::*;
#(
    parameter int NARRAY  = 2,
    parameter int NWORD   = 3,
    parameter int N       = NWORD + NARRAY,
    parameter int NSUB    = 2 ** NARRAY,
    parameter int PULSE_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [1:0]              mode,
    input  logic [N-1:0]            adr_full_row,
    input  logic [PULSE_W-1:0]      pulse_len,
    output logic                    busy,
    output logic                    done,
    output logic [NSUB-1:0]         sel,
    output logic [NSUB-1:0]         cwl_en,
    output logic [NWORD-1:0]        row_adr,
    output logic [NWORD+2*NSUB-1:0] reg_lrs
);

    state_e             state, state_nxt;
    mode_e              op_mode, op_mode_nxt;
    logic [PULSE_W-1:0] len_m1, len_m1_nxt;
    logic [NSUB-1:0]    sel_nxt, cwl_nxt, start_sel;
    logic [NWORD-1:0]   row_nxt;
    logic               busy_nxt, done_nxt;
    logic               t_load, t_dec, t_tc;
    logic [PULSE_W-1:0] t_count;
    logic [NARRAY-1:0]  sub_adr;
    logic [MAX_SUB-1:0] dec_sel;
    logic               unused_dec;

    assign sub_adr    = adr_full_row[N-1:NWORD];
    assign dec_sel    = onehot_sel(MAX_ARRAY'(sub_adr));
    assign start_sel  = dec_sel[NSUB-1:0];
    assign unused_dec = ^{dec_sel[MAX_SUB-1:NSUB], t_count};
    assign reg_lrs    = {sel, cwl_en, row_adr};

    cwl_pulse_timer #(
        .PULSE_W (PULSE_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .dec      (t_dec),
        .load_val (len_m1),
        .count    (t_count),
        .tc       (t_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            op_mode <= MODE_WRITE;
            len_m1  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sel     <= '0;
            cwl_en  <= '0;
            row_adr <= '0;
        end else begin
            state   <= state_nxt;
            op_mode <= op_mode_nxt;
            len_m1  <= len_m1_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            sel     <= sel_nxt;
            cwl_en  <= cwl_nxt;
            row_adr <= row_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        op_mode_nxt = op_mode;
        len_m1_nxt  = len_m1;
        sel_nxt     = sel;
        row_nxt     = row_adr;
        t_load      = 1'b0;
        t_dec       = 1'b0;
        if (abort) begin
            state_nxt = S_IDLE;
            sel_nxt   = '0;
            row_nxt   = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        op_mode_nxt = mode_e'(mode);
                        // A zero length still yields a one-cycle pulse.
                        len_m1_nxt  = (pulse_len == '0) ? '0
                                    : pulse_len - PULSE_W'(1);
                        if (mode_e'(mode) == MODE_READOUT) begin
                            state_nxt = S_CLEAR;
                            sel_nxt   = '0;
                            row_nxt   = '0;
                        end else begin
                            state_nxt = S_SETUP;
                            sel_nxt   = (mode_e'(mode) == MODE_WRITE)
                                      ? start_sel : '1;
                            row_nxt   = (mode_e'(mode) == MODE_SCAN)
                                      ? '0 : adr_full_row[NWORD-1:0];
                        end
                    end
                end
                S_SETUP: begin
                    state_nxt = S_PULSE;
                    t_load    = 1'b1;
                end
                S_PULSE: begin
                    if (t_tc) state_nxt = S_HOLD;
                    else t_dec = 1'b1;
                end
                S_HOLD: begin
                    if (op_mode == MODE_SCAN && row_adr != '1) begin
                        state_nxt = S_SETUP;
                        row_nxt   = row_adr + NWORD'(1);
                    end else begin
                        state_nxt = S_FIN;
                    end
                end
                S_CLEAR: state_nxt = S_FIN;
                S_FIN:   state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
        busy_nxt = (state_nxt == S_SETUP) || (state_nxt == S_PULSE)
                || (state_nxt == S_HOLD)  || (state_nxt == S_CLEAR);
        done_nxt = (state_nxt == S_FIN);
        cwl_nxt  = (state_nxt == S_PULSE) ? sel_nxt : '0;
    end

endmodule
